autoanim_ctrl: RTL and testbench

- Controls the sprite auto-animation tile counter.
- Latches the auto-animation speed and disable bits from CPU writes to the LSPC mode register.
- Runs a frame-based reload timer, clocked by the vertical-blank pulse, and advances a 3-bit tile counter.
- Its outputs feed the sprite tile-number substitution logic. It replaces free-running counter chains with a sequenced state machine, so speed changes and enable/disable take effect at defined points.

---
 rtl/autoanim_ctrl.sv | 108 ++++++++++
 tb/tb_autoanim_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/autoanim_ctrl.sv
// rtl/autoanim_ctrl.sv - sprite auto-animation tile counter with frame reload timer
// Optional AUTOANIM_TESTMODE_EN adds TEST_MODE: RUN then ticks on every clock cycle.
module autoanim_ctrl #(
    parameter int SPEED_W = 8,
    parameter int COUNT_W = 3
) (
    input  logic               CLK,
    input  logic               RESETP,
    input  logic               REG_WR,
    input  logic [15:0]        REG_DIN,
    input  logic               VBLANK_P,
    input  logic               AA_CLR,
`ifdef AUTOANIM_TESTMODE_EN
    input  logic               TEST_MODE,
`endif
    output logic [COUNT_W-1:0] AA_COUNT,
    output logic               AA_STEP,
    output logic [SPEED_W-1:0] AA_SPEED_RD,
    output logic               AA_DISABLE
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARM      = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SPEED_W-1:0] timer;
    logic               run_en;
    logic               arm_load;
    logic               tick;
    logic               unused_din;

    assign unused_din = ^{REG_DIN[7:4], REG_DIN[2:0]};

`ifdef AUTOANIM_TESTMODE_EN
    assign tick = VBLANK_P | TEST_MODE;
`else
    assign tick = VBLANK_P;
`endif

    always_ff @(posedge CLK or posedge RESETP) begin
        if (RESETP) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (REG_WR && REG_DIN[3]) state_nxt = ST_DISABLED;
            end
            ST_DISABLED: begin
                if (REG_WR && !REG_DIN[3]) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                state_nxt = (REG_WR && REG_DIN[3]) ? ST_DISABLED : ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        run_en   = 1'b0;
        arm_load = 1'b0;
        case (state)
            ST_RUN: run_en   = 1'b1;
            ST_ARM: arm_load = 1'b1;
            default: ;
        endcase
    end

    // All timer/counter decisions use the pre-write shadow value; a write lands on the same edge.
    always_ff @(posedge CLK or posedge RESETP) begin
        if (RESETP) begin
            AA_COUNT    <= '0;
            timer       <= '0;
            AA_SPEED_RD <= '0;
            AA_DISABLE  <= 1'b0;
            AA_STEP     <= 1'b0;
        end else begin
            AA_STEP <= 1'b0;
            if (AA_CLR) begin
                AA_COUNT <= '0;
                timer    <= AA_SPEED_RD;
            end else if (arm_load) begin
                timer <= AA_SPEED_RD;
            end else if (run_en && tick) begin
                if (timer == '0) begin
                    timer    <= AA_SPEED_RD;
                    AA_COUNT <= AA_COUNT + 1'b1;
                    AA_STEP  <= 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
            if (REG_WR) begin
                AA_SPEED_RD <= REG_DIN[8 +: SPEED_W];
                AA_DISABLE  <= REG_DIN[3];
            end
        end
    end

endmodule

// File: tb/tb_autoanim_ctrl.sv
// tb/tb_autoanim_ctrl.sv - directed self-checking bench for autoanim_ctrl
module tb_autoanim_ctrl;

    logic        CLK = 1'b0;
    logic        RESETP;
    logic        REG_WR;
    logic [15:0] REG_DIN;
    logic        VBLANK_P;
    logic        AA_CLR;
    logic [2:0]  AA_COUNT;
    logic        AA_STEP;
    logic [7:0]  AA_SPEED_RD;
    logic        AA_DISABLE;

    int n_checks = 0;
    int n_fail   = 0;

    autoanim_ctrl #(.SPEED_W(8), .COUNT_W(3)) dut (
        .CLK         (CLK),
        .RESETP      (RESETP),
        .REG_WR      (REG_WR),
        .REG_DIN     (REG_DIN),
        .VBLANK_P    (VBLANK_P),
        .AA_CLR      (AA_CLR),
`ifdef AUTOANIM_TESTMODE_EN
        .TEST_MODE   (1'b0),
`endif
        .AA_COUNT    (AA_COUNT),
        .AA_STEP     (AA_STEP),
        .AA_SPEED_RD (AA_SPEED_RD),
        .AA_DISABLE  (AA_DISABLE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the rising edge.
    task automatic cyc(input logic vb, input logic wr, input logic [15:0] din, input logic clr);
        @(negedge CLK);
        VBLANK_P = vb;
        REG_WR   = wr;
        REG_DIN  = din;
        AA_CLR   = clr;
        @(posedge CLK);
        #1;
        VBLANK_P = 1'b0;
        REG_WR   = 1'b0;
        REG_DIN  = 16'h0000;
        AA_CLR   = 1'b0;
    endtask

    task automatic frame(input string tag, input logic [2:0] exp_count, input logic exp_step);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        check({tag, "_count"}, AA_COUNT, exp_count);
        check({tag, "_step"}, AA_STEP, exp_step);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        check({tag, "_step_drop"}, AA_STEP, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESETP = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESETP = 1'b0;
    endtask

    initial begin
        RESETP   = 1'b1;
        REG_WR   = 1'b0;
        REG_DIN  = 16'h0000;
        VBLANK_P = 1'b0;
        AA_CLR   = 1'b0;
        do_reset();
        check("rst_count", AA_COUNT, 3'd0);
        check("rst_step", AA_STEP, 1'b0);
        check("rst_speed", AA_SPEED_RD, 8'h00);
        check("rst_disable", AA_DISABLE, 1'b0);

        // Speed 0 from reset: every frame steps, wrapping 7 -> 0.
        for (int i = 1; i <= 10; i++) frame("t1", 3'(i % 8), 1'b1);
        check("t1_final", AA_COUNT, 3'd2);

        // Speed 3: first frame steps (timer 0), then every 4th frame.
        do_reset();
        cyc(1'b0, 1'b1, 16'h0300, 1'b0);
        check("t2_speed", AA_SPEED_RD, 8'h03);
        check("t2_disable", AA_DISABLE, 1'b0);
        for (int i = 1; i <= 16; i++)
            frame("t2", 3'((i + 3) / 4), ((i - 1) % 4) == 0);
        check("t2_final", AA_COUNT, 3'd4);

        // Bring timer to 2, then drop speed to 0: old timer runs out first.
        frame("t3_pre", 3'd5, 1'b1);
        frame("t3_pre", 3'd5, 1'b0);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        frame("t3_a", 3'd5, 1'b0);
        frame("t3_b", 3'd5, 1'b0);
        frame("t3_c", 3'd6, 1'b1);
        frame("t3_d", 3'd7, 1'b1);
        frame("t3_e", 3'd0, 1'b1);

        // Disable freezes; re-enable with speed 1 passes through one ARM cycle.
        cyc(1'b0, 1'b1, 16'h0008, 1'b0);
        check("t4_disable", AA_DISABLE, 1'b1);
        for (int i = 0; i < 20; i++) frame("t4_frozen", 3'd0, 1'b0);
        cyc(1'b0, 1'b1, 16'h0100, 1'b0);
        check("t4_reenable", AA_DISABLE, 1'b0);
        check("t4_speed", AA_SPEED_RD, 8'h01);
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        check("t4_arm_count", AA_COUNT, 3'd0);
        check("t4_arm_step", AA_STEP, 1'b0);
        frame("t4_r1", 3'd0, 1'b0);
        frame("t4_r2", 3'd1, 1'b1);
        frame("t4_r3", 3'd1, 1'b0);
        frame("t4_r4", 3'd2, 1'b1);
        frame("t4_r5", 3'd2, 1'b0);

        // Timer now 0: clear wins over a stepping frame and reloads speed 1.
        cyc(1'b1, 1'b0, 16'h0000, 1'b1);
        check("t5_clr_count", AA_COUNT, 3'd0);
        check("t5_clr_step", AA_STEP, 1'b0);
        frame("t5_a", 3'd0, 1'b0);
        // Reload coinciding with a speed write uses the old speed (1).
        cyc(1'b1, 1'b1, 16'h0000, 1'b0);
        check("t5_wr_count", AA_COUNT, 3'd1);
        check("t5_wr_step", AA_STEP, 1'b1);
        check("t5_wr_speed", AA_SPEED_RD, 8'h00);
        frame("t5_b", 3'd1, 1'b0);
        frame("t5_c", 3'd2, 1'b1);
        frame("t5_d", 3'd3, 1'b1);

        // Reach count 5 at speed 4, then reset between clock edges.
        cyc(1'b0, 1'b1, 16'h0400, 1'b0);
        frame("t6_a", 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) frame("t6_wait", 3'd4, 1'b0);
        frame("t6_b", 3'd5, 1'b1);
        check("t6_pre_speed", AA_SPEED_RD, 8'h04);
        #2;
        RESETP = 1'b1;
        #1;
        check("t6_async_count", AA_COUNT, 3'd0);
        check("t6_async_speed", AA_SPEED_RD, 8'h00);
        check("t6_async_disable", AA_DISABLE, 1'b0);
        check("t6_async_step", AA_STEP, 1'b0);
        @(negedge CLK);
        RESETP = 1'b0;
        frame("t6_after", 3'd1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
